ram_wt: RTL and testbench
=========================

# ram_wt

Write-side partner of the RAM read decoder. It owns the eight 16-bit data RAM words and the IO64 output port, and accepts one write request at a time from the execute/write-back stage through a ready/request handshake. It commits the data to the addressed word and reports completion. Its RAM_0..RAM_7 outputs feed the read decoder directly, so the decoder always sees the committed storage.

## Interface
Parameters:
- DATA_W, 16, width of every RAM word and of the IO port.
- RAM_WORDS, 8, number of RAM words, mapped at addresses 0x00..0x07.
- IO64_AD, 8'h40, address of the output port.

Ports:
- CLK_WT, in, 1, write-stage clock; the only clock. All state changes on its rising edge.
- RESET_N, in, 1, asynchronous, active-low reset.
- WR_REQ, in, 1, write request; sampled only while WR_RDY=1.
- WR_AD, in, 8, write address; valid with WR_REQ.
- WR_DATA, in, DATA_W, write data; valid with WR_REQ.
- WR_RDY, out, 1, block can accept a request this cycle.
- WR_DONE, out, 1, one-cycle pulse: request finished, mapped or not.
- WR_ERR, out, 1, one-cycle pulse with WR_DONE: address unmapped, nothing written.
- RAM_0 .. RAM_7, out, DATA_W each, registered RAM word contents.
- IO64_OUT, out, DATA_W, registered output-port value.
- IO64_STB, out, 1, one-cycle pulse: IO64_OUT was just updated.

## Operation
- FSM has two states: IDLE and COMMIT.
- WR_RDY = (state == IDLE). It is combinational from the state register.
- **IDLE:** if WR_REQ=1, capture WR_AD and WR_DATA into hold registers and go to COMMIT. Otherwise stay in IDLE.
- **COMMIT:** decode the held address and return to IDLE unconditionally.
  - Address 0x00..0x07: write the hold data to RAM_n. Set WR_DONE for the next cycle.
  - Address IO64_AD: write IO64_OUT and set IO64_STB and WR_DONE for the next cycle.
  - Any other address, including 0x41 (IO65, input-only): leave all storage unchanged and set WR_DONE and WR_ERR for the next cycle.
- WR_REQ is ignored in COMMIT. The requester must hold or re-present the request until it sees WR_RDY=1.
- WR_AD and WR_DATA may change freely after the capture edge; only the hold registers are used.
- Writing the same value to a word is still a full write: WR_DONE pulses, and IO64_STB pulses for the port.
- Reset values:
  - state IDLE, so WR_RDY=1 during reset.
  - WR_DONE=0, WR_ERR=0, IO64_STB=0.
  - RAM_0..RAM_7=0, IO64_OUT=0, hold registers=0.
- Reset asserted mid-operation (state COMMIT): the write is abandoned, no storage changes, no pulses are produced, and all outputs take their reset values immediately.

## Timing
- Request accepted at rising edge k (WR_RDY=1 and WR_REQ=1 before k).
- Commit happens at edge k+1:
  - the new RAM_n or IO64_OUT value is visible after k+1;
  - WR_DONE, WR_ERR and IO64_STB are high for exactly the cycle between k+1 and k+2;
  - WR_RDY is high again after k+1.
- A new request may be accepted at edge k+2 while WR_DONE from the previous request is still high.
- Latency: 1 cycle from accept to storage update.
- Throughput: 1 write per 2 cycles under back-to-back requests.
- Read-after-write: the read decoder sampling on an edge at or after k+2 sees the new value.
- Pulses never stretch. Two consecutive writes give two separate WR_DONE pulses with at least one low cycle between them.

## Structure
- Shared package cpu15_pkg holds:
  - DATA_W;
  - address constants RAM_AD_FIRST=8'h00, RAM_AD_LAST=8'h07, IO64_AD=8'h40, IO65_AD=8'h41;
  - the two-state FSM encoding.
- Both this block and the read decoder use the package address constants.
- Single module, no sub-module. Address decode is a small function, and the storage is a register array unpacked onto RAM_0..RAM_7.

## Test plan
- **Reset:** hold RESET_N=0 -> WR_RDY=1, all RAM words, IO64_OUT and every pulse = 0. Assert RESET_N mid-COMMIT of a write of 0xBEEF to address 3 -> RAM_3 stays 0 and no WR_DONE pulse.
- **Basic write:** write WR_AD=0x05, WR_DATA=0x1234 -> WR_RDY=0 for one cycle, RAM_5=0x1234 one cycle after accept, WR_DONE=1 for one cycle, WR_ERR=0, all other words unchanged.
- **IO port:** write WR_AD=0x40, WR_DATA=0x00FF -> IO64_OUT=0x00FF, IO64_STB and WR_DONE pulse together for one cycle.
- **Unmapped:** write WR_AD=0x41 with 0xAAAA, then WR_AD=0x08 with 0x5555 -> each gives WR_DONE+WR_ERR pulses and no storage or IO64_OUT change.
- **Back-to-back:** hold WR_REQ=1 while sweeping addresses 0..7 with data 0x1000+n -> one accept every 2 cycles, RAM_n=0x1000+n, 8 WR_DONE pulses. Input changes made during COMMIT are ignored.
- **Read-after-write:** write 0xCAFE to address 2, then issue a read-decoder read of address 2 two cycles after accept -> read returns 0xCAFE.

Source files
------------

// File: rtl/cpu15_pkg.sv
// Shared definitions for the cpu15 data-memory write and read paths.
`default_nettype none

package cpu15_pkg;

  localparam int DATA_W = 16;

  localparam logic [7:0] RAM_AD_FIRST = 8'h00;
  localparam logic [7:0] RAM_AD_LAST  = 8'h07;
  localparam logic [7:0] IO64_AD      = 8'h40;
  localparam logic [7:0] IO65_AD      = 8'h41;

  localparam int RAM_WORDS = int'(RAM_AD_LAST) - int'(RAM_AD_FIRST) + 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } wt_state_e;

  typedef enum logic [1:0] {
    AD_RAM = 2'd0,
    AD_IO  = 2'd1,
    AD_BAD = 2'd2
  } ad_kind_e;

  // IO65 is an input-only port, so a write to it is reported as unmapped.
  function automatic ad_kind_e decode_wr_ad(input logic [7:0] ad,
                                            input logic [7:0] io_ad,
                                            input int         words);
    ad_kind_e kind;
    kind = AD_BAD;
    if (int'(ad) - int'(RAM_AD_FIRST) < words && int'(ad) >= int'(RAM_AD_FIRST))
      kind = AD_RAM;
    else if (ad == io_ad && ad != IO65_AD)
      kind = AD_IO;
    return kind;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_wt.sv
// Write side of the data RAM: owns RAM_0..RAM_7 and IO64, commits one
// handshaked write every two cycles and pulses completion/error/strobe.
`default_nettype none

module ram_wt #(
  parameter int         DATA_W    = cpu15_pkg::DATA_W,
  parameter int         RAM_WORDS = cpu15_pkg::RAM_WORDS,
  parameter logic [7:0] IO64_AD   = cpu15_pkg::IO64_AD
) (
  input  logic              CLK_WT,
  input  logic              RESET_N,
  input  logic              WR_REQ,
  input  logic [7:0]        WR_AD,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_RDY,
  output logic              WR_DONE,
  output logic              WR_ERR,
  output logic [DATA_W-1:0] RAM_0,
  output logic [DATA_W-1:0] RAM_1,
  output logic [DATA_W-1:0] RAM_2,
  output logic [DATA_W-1:0] RAM_3,
  output logic [DATA_W-1:0] RAM_4,
  output logic [DATA_W-1:0] RAM_5,
  output logic [DATA_W-1:0] RAM_6,
  output logic [DATA_W-1:0] RAM_7,
  output logic [DATA_W-1:0] IO64_OUT,
  output logic              IO64_STB
);
  import cpu15_pkg::*;

  localparam int AW = $clog2(RAM_WORDS);

  wt_state_e         state_q, state_d;
  logic [7:0]        hold_ad_q, hold_ad_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [DATA_W-1:0] ram_q [RAM_WORDS];
  logic [DATA_W-1:0] ram_d [RAM_WORDS];
  logic [DATA_W-1:0] io64_q, io64_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              stb_q, stb_d;
  ad_kind_e          kind;

  assign kind = decode_wr_ad(hold_ad_q, IO64_AD, RAM_WORDS);

  always_comb begin
    state_d     = state_q;
    hold_ad_d   = hold_ad_q;
    hold_data_d = hold_data_q;
    ram_d       = ram_q;
    io64_d      = io64_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    stb_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (WR_REQ) begin
          hold_ad_d   = WR_AD;
          hold_data_d = WR_DATA;
          state_d     = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // Only the hold registers are used here; WR_* may already have moved on.
        state_d = ST_IDLE;
        done_d  = 1'b1;
        case (kind)
          AD_RAM:  ram_d[hold_ad_q[AW-1:0]] = hold_data_q;
          AD_IO: begin
            io64_d = hold_data_q;
            stb_d  = 1'b1;
          end
          default: err_d = 1'b1;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_WT or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      hold_ad_q   <= '0;
      hold_data_q <= '0;
      for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
      io64_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_ad_q   <= hold_ad_d;
      hold_data_q <= hold_data_d;
      ram_q       <= ram_d;
      io64_q      <= io64_d;
      done_q      <= done_d;
      err_q       <= err_d;
      stb_q       <= stb_d;
    end
  end

  assign WR_RDY   = (state_q == ST_IDLE);
  assign WR_DONE  = done_q;
  assign WR_ERR   = err_q;
  assign IO64_STB = stb_q;
  assign IO64_OUT = io64_q;
  assign RAM_0    = ram_q[0];
  assign RAM_1    = ram_q[1];
  assign RAM_2    = ram_q[2];
  assign RAM_3    = ram_q[3];
  assign RAM_4    = ram_q[4];
  assign RAM_5    = ram_q[5];
  assign RAM_6    = ram_q[6];
  assign RAM_7    = ram_q[7];

endmodule

`default_nettype wire

// File: tb/tb_ram_wt.sv
// Directed, table-driven bench for ram_wt.
`default_nettype none

module tb_ram_wt;

  logic        clk;
  logic        rst_n;
  logic        wr_req;
  logic [7:0]  wr_ad;
  logic [15:0] wr_data;
  logic        wr_rdy, wr_done, wr_err, io64_stb;
  logic [15:0] io64_out;
  logic [15:0] ram_w [8];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  logic [15:0] mem_m [8];
  logic [15:0] io_m;

  typedef struct {
    logic [7:0]  ad;
    logic [15:0] data;
    logic        exp_err;
    logic        exp_stb;
  } vec_t;

  vec_t vecs [8];

  ram_wt dut (
    .CLK_WT   (clk),
    .RESET_N  (rst_n),
    .WR_REQ   (wr_req),
    .WR_AD    (wr_ad),
    .WR_DATA  (wr_data),
    .WR_RDY   (wr_rdy),
    .WR_DONE  (wr_done),
    .WR_ERR   (wr_err),
    .RAM_0    (ram_w[0]),
    .RAM_1    (ram_w[1]),
    .RAM_2    (ram_w[2]),
    .RAM_3    (ram_w[3]),
    .RAM_4    (ram_w[4]),
    .RAM_5    (ram_w[5]),
    .RAM_6    (ram_w[6]),
    .RAM_7    (ram_w[7]),
    .IO64_OUT (io64_out),
    .IO64_STB (io64_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (wr_done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout want finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_storage(input string nm);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s RAM_%0d", nm, i), {16'h0, ram_w[i]}, {16'h0, mem_m[i]});
    chk({nm, " IO64_OUT"}, {16'h0, io64_out}, {16'h0, io_m});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full single write; called #1 after a rising edge with the block idle.
  task automatic do_write(input vec_t v);
    chk("rdy before accept", wr_rdy, 1);
    wr_req  = 1'b1;
    wr_ad   = v.ad;
    wr_data = v.data;
    tick();                                  // accept edge k
    wr_req  = 1'b0;
    wr_ad   = 8'h03;
    wr_data = ~v.data;
    chk("rdy in commit", wr_rdy, 0);
    chk("done before commit", wr_done, 0);
    tick();                                  // commit edge k+1
    if (!v.exp_err) begin
      if (v.exp_stb) io_m = v.data;
      else mem_m[v.ad[2:0]] = v.data;
    end
    chk("rdy after commit", wr_rdy, 1);
    chk("done pulse", wr_done, 1);
    chk("err pulse", wr_err, v.exp_err);
    chk("stb pulse", io64_stb, v.exp_stb);
    chk_storage($sformatf("after wr %h", v.ad));
    tick();                                  // k+2
    chk("done falls", wr_done, 0);
    chk("err falls", wr_err, 0);
    chk("stb falls", io64_stb, 0);
  endtask

  initial begin
    int cnt0;
    int waited;
    logic [15:0] rd;

    vecs[0] = '{8'h05, 16'h1234, 1'b0, 1'b0};
    vecs[1] = '{8'h40, 16'h00FF, 1'b0, 1'b1};
    vecs[2] = '{8'h41, 16'hAAAA, 1'b1, 1'b0};
    vecs[3] = '{8'h08, 16'h5555, 1'b1, 1'b0};
    vecs[4] = '{8'h40, 16'h00FF, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 16'hFFFF, 1'b0, 1'b0};
    vecs[6] = '{8'h07, 16'h8001, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 16'h0001, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) mem_m[i] = 16'h0;
    io_m    = 16'h0;
    rst_n   = 1'b0;
    wr_req  = 1'b0;
    wr_ad   = 8'h00;
    wr_data = 16'h0;

    tick();
    tick();
    chk("reset rdy", wr_rdy, 1);
    chk("reset done", wr_done, 0);
    chk("reset err", wr_err, 0);
    chk("reset stb", io64_stb, 0);
    chk_storage("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset landing in COMMIT abandons the write.
    cnt0    = done_cnt;
    wr_req  = 1'b1;
    wr_ad   = 8'h03;
    wr_data = 16'hBEEF;
    tick();
    wr_req = 1'b0;
    chk("mid reset in commit", wr_rdy, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid reset rdy async", wr_rdy, 1);
    tick();
    chk("mid reset RAM_3", {16'h0, ram_w[3]}, 32'h0);
    chk("mid reset done", wr_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("mid reset no pulse", done_cnt - cnt0, 0);
    chk_storage("mid reset");

    for (int i = 0; i < 8; i++) do_write(vecs[i]);

    // Back-to-back sweep with WR_REQ held high; garbage inputs during COMMIT.
    cnt0   = done_cnt;
    wr_req = 1'b1;
    for (int n = 0; n < 8; n++) begin
      waited = 0;
      while (!wr_rdy && waited < 10) begin
        tick();
        waited++;
      end
      chk($sformatf("b2b rdy wait %0d", n), waited, 0);
      wr_ad   = 8'(n);
      wr_data = 16'h1000 + 16'(n);
      tick();
      chk($sformatf("b2b busy %0d", n), wr_rdy, 0);
      wr_ad   = 8'h40;
      wr_data = 16'hDEAD;
      tick();
      mem_m[n] = 16'h1000 + 16'(n);
      chk($sformatf("b2b done %0d", n), wr_done, 1);
      chk($sformatf("b2b RAM_%0d", n), {16'h0, ram_w[n]}, {16'h0, mem_m[n]});
    end
    wr_req = 1'b0;
    tick();
    tick();
    chk("b2b pulse count", done_cnt - cnt0, 8);
    chk_storage("b2b");

    // Read-after-write: a decoder sampling two cycles after accept.
    wr_req  = 1'b1;
    wr_ad   = 8'h02;
    wr_data = 16'hCAFE;
    tick();
    wr_req  = 1'b0;
    wr_data = 16'h0000;
    tick();
    @(negedge clk);
    rd = ram_w[wr_ad[2:0] | 3'd2];
    chk("raw read addr 2", {16'h0, rd}, 32'h0000_CAFE);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
